// File: rtl/berlekamp_massey_4.sv
// Inversionless Berlekamp-Massey key-equation solver for RS(15,11) over GF(16), t=2.
// Optional BM_NORMALISE_EN adds a NORM cycle that scales Lambda so Lambda0=1.
module berlekamp_massey_4 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] IN_SERIAL,
  input  logic       IN_VALID,
  output logic [3:0] OUT_SERIAL,
  output logic       OUT_VALID,
  output logic       BUSY,
  output logic [1:0] ERR_COUNT,
  output logic       UNCORRECTABLE
);

  localparam logic [4:0] GF_POLY = 5'b10011;
  localparam int         NSYN    = 4;

  typedef enum logic [1:0] {ST_LOAD, ST_ITER, ST_NORM, ST_OUT} state_t;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({4'b0, a} << i);
    for (int k = 7; k >= 4; k--)
      if (p[k]) p = p ^ ({3'b0, GF_POLY} << (k - 4));
    return p[3:0];
  endfunction

  // Failure if L exceeds t, L disagrees with the actual degree, or Lambda3 survives.
  function automatic logic calc_uncorr(input logic [3:0][3:0] lam, input logic [2:0] l);
    logic [2:0] deg;
    deg = '0;
    for (int j = 1; j < 4; j++)
      if (lam[j] != 4'h0) deg = 3'(j);
    return (l > 3'd2) || (deg != l) || (lam[3] != 4'h0);
  endfunction

`ifdef BM_NORMALISE_EN
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    case (a)
      4'h1: return 4'h1;  4'h2: return 4'h9;  4'h3: return 4'hE;  4'h4: return 4'hD;
      4'h5: return 4'hB;  4'h6: return 4'h7;  4'h7: return 4'h6;  4'h8: return 4'hF;
      4'h9: return 4'h2;  4'hA: return 4'hC;  4'hB: return 4'h5;  4'hC: return 4'hA;
      4'hD: return 4'h4;  4'hE: return 4'h3;  4'hF: return 4'h8;
      default: return 4'h0;
    endcase
  endfunction
`endif

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cnt, r_r, r_oidx;
  logic [3:0][3:0]  r_syn, r_lam, r_b;
  logic [3:0]       r_gamma;
  logic [2:0]       r_l;
  logic [1:0]       r_err_cnt;
  logic             r_uncorr;

  logic [3:0]       w_delta;
  logic [3:0][3:0]  w_lam_nxt, w_b_nxt;
  logic [2:0]       w_l_nxt;
  logic             w_upd;
  logic [1:0]       w_idx;

  always_comb begin
    w_delta = '0;
    w_idx   = '0;
    for (int j = 0; j < 4; j++) begin
      w_idx = r_r - 2'(j);
      if (j <= int'(r_r)) w_delta = w_delta ^ gf_mul(r_lam[j], r_syn[w_idx]);
    end
    for (int j = 0; j < 4; j++) begin
      w_lam_nxt[j] = gf_mul(r_gamma, r_lam[j]);
      if (j > 0) w_lam_nxt[j] = w_lam_nxt[j] ^ gf_mul(w_delta, r_b[j-1]);
    end
    w_upd   = (w_delta != 4'h0) && ({r_l, 1'b0} <= {2'b0, r_r});
    w_b_nxt = w_upd ? r_lam : {r_b[2:0], 4'h0};
    w_l_nxt = w_upd ? ({1'b0, r_r} + 3'd1 - r_l) : r_l;
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    OUT_VALID   = 1'b0;
    BUSY        = 1'b1;
    OUT_SERIAL  = 4'h0;
    case (r_state)
      ST_LOAD: begin
        BUSY = 1'b0;
        if (IN_VALID && r_cnt == 2'(NSYN - 1)) w_state_nxt = ST_ITER;
      end
      ST_ITER: begin
`ifdef BM_NORMALISE_EN
        if (r_r == 2'd3) w_state_nxt = ST_NORM;
`else
        if (r_r == 2'd3) w_state_nxt = ST_OUT;
`endif
      end
      ST_NORM: w_state_nxt = ST_OUT;
      ST_OUT: begin
        OUT_VALID  = 1'b1;
        OUT_SERIAL = r_lam[r_oidx];
        if (r_oidx == 2'd2) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt     <= '0;
      r_r       <= '0;
      r_oidx    <= '0;
      r_syn     <= '0;
      r_lam     <= {4'h0, 4'h0, 4'h0, 4'h1};
      r_b       <= {4'h0, 4'h0, 4'h0, 4'h1};
      r_gamma   <= 4'h1;
      r_l       <= '0;
      r_err_cnt <= '0;
      r_uncorr  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: if (IN_VALID) begin
          r_syn[r_cnt] <= IN_SERIAL;
          r_cnt        <= r_cnt + 2'd1;
          if (r_cnt == 2'(NSYN - 1)) begin
            r_r       <= '0;
            r_lam     <= {4'h0, 4'h0, 4'h0, 4'h1};
            r_b       <= {4'h0, 4'h0, 4'h0, 4'h1};
            r_gamma   <= 4'h1;
            r_l       <= '0;
            r_err_cnt <= '0;
            r_uncorr  <= 1'b0;
          end
        end
        ST_ITER: begin
          r_lam  <= w_lam_nxt;
          r_b    <= w_b_nxt;
          r_l    <= w_l_nxt;
          r_r    <= r_r + 2'd1;
          r_oidx <= '0;
          if (w_upd) r_gamma <= w_delta;
`ifndef BM_NORMALISE_EN
          if (r_r == 2'd3) begin
            r_err_cnt <= w_l_nxt[1:0];
            r_uncorr  <= calc_uncorr(w_lam_nxt, w_l_nxt);
          end
`endif
        end
`ifdef BM_NORMALISE_EN
        ST_NORM: begin
          r_err_cnt <= r_l[1:0];
          r_uncorr  <= calc_uncorr(r_lam, r_l) || (r_lam[0] == 4'h0);
          if (r_lam[0] != 4'h0)
            for (int j = 0; j < 4; j++) r_lam[j] <= gf_mul(gf_inv(r_lam[0]), r_lam[j]);
        end
`endif
        ST_OUT: r_oidx <= r_oidx + 2'd1;
        default: ;
      endcase
    end
  end

  assign ERR_COUNT     = r_err_cnt;
  assign UNCORRECTABLE = r_uncorr;

endmodule
